// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the MEM-stage data port arbiter.
//   STARVE_W        : width of the DMA starvation counter
//   IO_SEL_BIT_DEF  : default address bit selecting I/O space (1) or data RAM (0)
//   STARVE_MAX_DEF  : default number of lost arbitrations before DMA is forced in
//   rd_owner_t      : owner tag of the read whose data returns next cycle
package dmem_port_arbiter_pkg;

  localparam int unsigned STARVE_W       = 4;
  localparam int unsigned IO_SEL_BIT_DEF = 7;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle around the data-port arbiter.
//   cpu_* : CPU MEM-stage request side (req/we/addr/wdata in, stall/rdata/rvalid out)
//   dma_* : DMA/debug-loader side (req/we/addr/wdata in, gnt/err/rdata/rvalid out)
//   mem_* : memory stage side (we/addr/wdata out, rdata in)
// modport master: requesters and memory stage; modport slave: the arbiter.
interface dmem_port_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_err;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_err, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_err, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating starvation counter for the DMA requester.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc          : DMA lost an arbitration this cycle
//   clr          : DMA granted, rejected or idle this cycle (wins over inc)
//   at_max       : counter has reached MAX; DMA takes the next contended slot
module dmem_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != STARVE_W'(MAX))) begin
      count <= count + STARVE_W'(1);
    end
  end

  assign at_max = (count == STARVE_W'(MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the MEM-stage data port between the CPU and a DMA/debug loader.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : cpu_*, dma_* and mem_* signals (slave modport)
// The CPU has priority; after STARVE_MAX consecutive lost arbitrations the
// DMA takes one slot and the CPU is stalled. DMA accesses to I/O space
// (addr[IO_SEL_BIT]=1) are rejected with dma_err. Read data returns one
// cycle after issue to the owner recorded in rd_owner_q.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned IO_SEL_BIT = IO_SEL_BIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  rd_owner_t   rd_owner_q, rd_owner_d;
  logic [31:0] cpu_rdata_q, dma_rdata_q;
  logic        cpu_win, dma_win, dma_err_c, at_max;
  logic        starve_inc, starve_clr;

  dmem_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clock  (clock),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // Grant and issue are combinational; reset masks every request so nothing
  // sampled in a reset cycle is issued or recorded.
  always_comb begin
    dma_err_c  = 1'b0;
    dma_win    = 1'b0;
    cpu_win    = 1'b0;
    rd_owner_d = OWN_NONE;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (!reset) begin
      dma_err_c = bus.dma_req && bus.dma_addr[IO_SEL_BIT];
      dma_win   = bus.dma_req && !bus.dma_addr[IO_SEL_BIT] && (!bus.cpu_req || at_max);
      cpu_win   = bus.cpu_req && !dma_win;
    end

    if (dma_win) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      rd_owner_d    = bus.dma_we ? OWN_NONE : OWN_DMA;
    end else if (cpu_win) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      rd_owner_d    = bus.cpu_we ? OWN_NONE : OWN_CPU;
    end
  end

  assign starve_inc    = cpu_win && bus.dma_req;
  assign starve_clr    = dma_win || dma_err_c || !bus.dma_req;

  assign bus.cpu_stall = dma_win && bus.cpu_req;
  assign bus.dma_gnt   = dma_win;
  assign bus.dma_err   = dma_err_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_owner_q  <= OWN_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
      if (rd_owner_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
    end
  end

  // Returning data is passed straight through in its valid cycle and held
  // afterwards; a read in flight when reset hits is dropped.
  always_comb begin
    bus.cpu_rvalid = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.cpu_rdata  = '0;
    bus.dma_rdata  = '0;
    if (!reset) begin
      bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
      bus.dma_rvalid = (rd_owner_q == OWN_DMA);
      bus.cpu_rdata  = (rd_owner_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
      bus.dma_rdata  = (rd_owner_q == OWN_DMA) ? bus.mem_rdata : dma_rdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: table of per-cycle vectors,
// read returns tracked through a scoreboard queue, and hand-built
// sequences for starvation and reset during an in-flight read.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic        stall, gnt, err, mwe;
    logic [31:0] maddr, mwd;
    rd_owner_t   rd;
  } vec_t;

  typedef struct {
    rd_owner_t   own;
    logic [31:0] data;
  } sb_t;

  logic clock = 1'b0;
  logic reset;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.STARVE_MAX(4), .IO_SEL_BIT(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic [31:0] exp_cr   = '0;
  logic [31:0] exp_dr   = '0;
  vec_t        tbl[$];
  sb_t         sb[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0000_1234 : (32'hD00D_0000 ^ a);
  endfunction

  // memory stage: read data one cycle after the address
  initial bus.mem_rdata = '0;
  always @(posedge clock) bus.mem_rdata <= mem_model(bus.mem_addr);

  function automatic vec_t vec(input logic rst, creq, cwe, input logic [31:0] caddr, cwd,
                               input logic dreq, dwe, input logic [31:0] daddr, dwd,
                               input logic stall, gnt, err, mwe,
                               input logic [31:0] maddr, mwd, input rd_owner_t rd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.stall = stall; v.gnt = gnt; v.err = err; v.mwe = mwe;
    v.maddr = maddr; v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    sb_t e;
    reset         = v.rst;
    bus.cpu_req   = v.creq;  bus.cpu_we = v.cwe;
    bus.cpu_addr  = v.caddr; bus.cpu_wdata = v.cwd;
    bus.dma_req   = v.dreq;  bus.dma_we = v.dwe;
    bus.dma_addr  = v.daddr; bus.dma_wdata = v.dwd;
    @(negedge clock);
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(v.stall));
    chk("dma_gnt",   32'(bus.dma_gnt),   32'(v.gnt));
    chk("dma_err",   32'(bus.dma_err),   32'(v.err));
    chk("mem_we",    32'(bus.mem_we),    32'(v.mwe));
    chk("mem_addr",  bus.mem_addr,       v.maddr);
    chk("mem_wdata", bus.mem_wdata,      v.mwd);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.own = OWN_NONE; e.data = '0; end
    if (v.rst) begin
      e.own  = OWN_NONE;
      exp_cr = '0;
      exp_dr = '0;
    end else if (e.own == OWN_CPU) exp_cr = e.data;
    else if (e.own == OWN_DMA) exp_dr = e.data;
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e.own == OWN_CPU));
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(e.own == OWN_DMA));
    chk("cpu_rdata",  bus.cpu_rdata, exp_cr);
    chk("dma_rdata",  bus.dma_rdata, exp_dr);
    e.own  = v.rst ? OWN_NONE : v.rd;
    e.data = mem_model(v.maddr);
    sb.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    @(posedge clock);
    #1;

    //                rst cr cw caddr     cwd        dr dw daddr     dwd          st gn er mw maddr     mwd
    tbl.push_back(vec(1, 1, 0, 32'h04,   Z,          1, 0, 32'h0C,   Z,           0, 0, 0, 0, Z,        Z,          OWN_NONE));
    tbl.push_back(vec(1, 0, 0, Z,        Z,          0, 0, Z,        Z,           0, 0, 0, 0, Z,        Z,          OWN_NONE));
    tbl.push_back(vec(0, 1, 0, 32'h04,   Z,          0, 0, Z,        Z,           0, 0, 0, 0, 32'h04,   Z,          OWN_CPU));
    tbl.push_back(vec(0, 0, 0, Z,        Z,          0, 0, Z,        Z,           0, 0, 0, 0, Z,        Z,          OWN_NONE));
    tbl.push_back(vec(0, 0, 0, Z,        Z,          1, 1, 32'h10,   32'hCAFE,    0, 1, 0, 1, 32'h10,   32'hCAFE,   OWN_NONE));
    tbl.push_back(vec(0, 0, 0, Z,        Z,          1, 0, 32'h80,   Z,           0, 0, 1, 0, Z,        Z,          OWN_NONE));
    tbl.push_back(vec(0, 1, 1, 32'h80,   32'h55,     1, 1, 32'h80,   32'h99,      0, 0, 1, 1, 32'h80,   32'h55,     OWN_NONE));
    tbl.push_back(vec(0, 0, 0, Z,        Z,          1, 0, 32'h0C,   Z,           0, 1, 0, 0, 32'h0C,   Z,          OWN_DMA));
    tbl.push_back(vec(0, 1, 0, 32'h08,   Z,          0, 0, Z,        Z,           0, 0, 0, 0, 32'h08,   Z,          OWN_CPU));
    tbl.push_back(vec(0, 0, 0, Z,        Z,          0, 0, Z,        Z,           0, 0, 0, 0, Z,        Z,          OWN_NONE));
    tbl.push_back(vec(0, 1, 1, 32'h14,   32'h77,     0, 0, Z,        Z,           0, 0, 0, 1, 32'h14,   32'h77,     OWN_NONE));
    tbl.push_back(vec(0, 1, 0, 32'h1C,   Z,          1, 0, 32'hC0,   Z,           0, 0, 1, 0, 32'h1C,   Z,          OWN_CPU));

    foreach (tbl[i]) step(tbl[i]);
    chk("starve_cnt_idle", 32'(dut.u_starve.count), 32'd0);

    // Starvation: both hold requests; CPU gets 4 slots, DMA forced on the 5th.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) v = vec(0, 1, 0, 32'h08, Z, 1, 0, 32'h0C, Z, 0, 0, 0, 0, 32'h08, Z, OWN_CPU);
      else       v = vec(0, 1, 0, 32'h08, Z, 1, 0, 32'h0C, Z, 1, 1, 0, 0, 32'h0C, Z, OWN_DMA);
      step(v);
      chk("starve_cnt", 32'(dut.u_starve.count), (i < 4) ? 32'(i + 1) : 32'd0);
    end
    step(vec(0, 1, 0, 32'h08, Z, 0, 0, Z, Z, 0, 0, 0, 0, 32'h08, Z, OWN_CPU));
    chk("starve_cnt_resume", 32'(dut.u_starve.count), 32'd0);
    step(vec(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, 0, 0, Z, Z, OWN_NONE));

    // Reset the cycle after a CPU read issue, with a nonzero starve count.
    step(vec(0, 1, 0, 32'h18, Z, 1, 0, 32'h0C, Z, 0, 0, 0, 0, 32'h18, Z, OWN_CPU));
    step(vec(0, 1, 0, 32'h04, Z, 1, 0, 32'h0C, Z, 0, 0, 0, 0, 32'h04, Z, OWN_CPU));
    chk("starve_cnt_pre_rst", 32'(dut.u_starve.count), 32'd2);
    step(vec(1, 1, 0, 32'h08, Z, 1, 0, 32'h0C, Z, 0, 0, 0, 0, Z, Z, OWN_NONE));
    chk("starve_cnt_rst", 32'(dut.u_starve.count), 32'd0);
    step(vec(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, 0, 0, Z, Z, OWN_NONE));
    step(vec(0, 0, 0, Z, Z, 1, 0, 32'h04, Z, 0, 1, 0, 0, 32'h04, Z, OWN_DMA));
    step(vec(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, 0, 0, Z, Z, OWN_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the MEM-stage data port (32-word data RAM plus memory-mapped I/O, selected by address bit 7) between the pipelined CPU and a secondary DMA/debug-loader requester. The CPU normally has priority. A starvation counter guarantees the DMA requester one slot after a bounded number of lost cycles; the CPU is stalled for that slot. The block sits between the EX/MEM pipeline register and the memory/I/O stage.

Parameters:
STARVE_MAX, 4, number of consecutive lost arbitrations after which DMA wins (1..15)
IO_SEL_BIT, 7, address bit that selects the I/O space (1) or data RAM (0)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU MEM stage wants an access this cycle
cpu_we  in  1  CPU access is a write
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_stall  out  1  freeze the pipeline; the CPU access was not issued this cycle
cpu_rdata  out  32  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
dma_req  in  1  DMA request; held stable until dma_gnt or dma_err
dma_we  in  1  DMA access is a write
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_gnt  out  1  DMA access issued this cycle
dma_err  out  1  DMA access rejected (I/O address)
dma_rdata  out  32  DMA read data
dma_rvalid  out  1  dma_rdata valid (one-cycle pulse)
mem_we  out  1  to memory stage write enable
mem_addr  out  32  to memory stage address
mem_wdata  out  32  to memory stage write data
mem_rdata  in  32  from memory stage read mux; valid one cycle after the address is issued

Interface rules: one clock; reset is synchronous and active-high.

Behaviour:
- One access is issued per cycle at most. Grant logic is combinational in the same cycle. mem_* carry the winner's address, data and write enable.
- When no requester wins, mem_we=0 and mem_addr/mem_wdata=0.
- Only cpu_req: the CPU is issued; cpu_stall=0.
- Only dma_req with dma_addr[IO_SEL_BIT]=0: DMA is issued; dma_gnt=1.
- Only dma_req with dma_addr[IO_SEL_BIT]=1: no issue; dma_err=1 for one cycle; no I/O side effects.
- Both requesting, starve_cnt<STARVE_MAX: CPU wins; dma_gnt=0.
- Both requesting, starve_cnt==STARVE_MAX, legal DMA address: DMA wins; cpu_stall=1; dma_gnt=1.
- DMA I/O-address rejection while the CPU is requesting: the CPU is issued and dma_err=1 in the same cycle.
- starve_cnt is a 4-bit register:
  - Increments (saturating at STARVE_MAX) when dma_req=1 and the CPU wins.
  - Clears when DMA is granted, when dma_err is asserted, or when dma_req=0.
- Read return uses a registered tag rd_owner in {NONE, CPU, DMA}, set to the issued read's owner (NONE for writes and idle cycles).
  - Next cycle: the owner's *_rvalid=1 and *_rdata=mem_rdata. The other requester's *_rdata holds its last value.
- Back-to-back reads by alternating owners each return correctly; one cycle of latency is always preserved.
- Reset: starve_cnt=0 and rd_owner=NONE. cpu_rvalid, dma_rvalid, cpu_stall, dma_gnt, dma_err and mem_we are 0; cpu_rdata and dma_rdata are 0.
- Reset asserted while a read is in flight: that read's rvalid is suppressed.
- Requests sampled during the reset cycle are ignored.
- cpu_stall is asserted only in a DMA-win cycle. It is never asserted when cpu_req=0.

Decomposition:
- Shared package:
  - rd_owner enum {OWN_NONE, OWN_CPU, OWN_DMA}
  - IO_SEL_BIT default
  - STARVE counter width constant (4)
- One natural sub-module: dmem_starve_counter (saturating counter with inc/clear/at_max). The remainder stays flat.

Test Plan:
- cpu_req read addr 0x04 only, mem_rdata=0x1234 next cycle -> mem_addr=0x04 in cycle 0, cpu_rvalid=1 and cpu_rdata=0x1234 in cycle 1, cpu_stall=0 throughout.
- dma_req write addr 0x10 data 0xCAFE, cpu idle -> dma_gnt=1, mem_we=1, mem_addr=0x10, mem_wdata=0xCAFE same cycle.
- cpu_req and dma_req held continuously, STARVE_MAX=4 -> CPU issued in cycles 0-3, DMA granted with cpu_stall=1 in cycle 4, CPU resumes in cycle 5, counter back at 0.
- dma_req addr 0x80 (I/O) -> dma_err=1 for one cycle, mem_we=0, no dma_gnt; a concurrent CPU write to 0x80 is issued normally.
- Alternating reads (CPU 0x08 then DMA 0x0C on the forced slot) -> each rvalid goes to the correct owner with the matching mem_rdata, no cross-delivery.
- reset asserted the cycle after a CPU read issue -> cpu_rvalid stays 0, all outputs 0, starve_cnt=0 after the edge.
